// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: show-ahead byte FIFO feeding the UART transmitter.
// Define UART_TX_FIFO_IRQ_EN to add the o_irq watermark/overflow pulse.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rstn,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_full,
  input  logic              i_flush,
  input  logic              i_ovf_clr,
  input  logic [ADDR_W:0]   i_thresh,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_req,
  output logic [ADDR_W:0]   o_level,
  output logic              o_empty,
  output logic              o_low,
  output logic              o_ovf_err
`ifdef UART_TX_FIFO_IRQ_EN
  ,
  output logic              o_irq
`endif
);

  localparam logic [ADDR_W:0] ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   level;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              ovf;

  // Full/empty from wrap-bit pointer compare; pop/push qualification.
  always_comb begin
    full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
            (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    empty = (wr_ptr == rd_ptr);
    pop   = i_tx_req & ~empty;
    push  = i_wr_en & (~full | pop);
    ovf   = i_wr_en & full & ~pop;
  end

  assign o_tx_data  = mem[rd_ptr[ADDR_W-1:0]];
  assign o_tx_valid = ~empty;
  assign o_empty    = empty;
  assign o_wr_full  = full;
  assign o_level    = level;
  assign o_low      = (level <= i_thresh);

  // Storage array; contents are never reset.
  always_ff @(posedge i_sys_clk) begin
    if (push && !i_flush) begin
      mem[wr_ptr[ADDR_W-1:0]] <= i_wr_data;
    end
  end

  // Pointers and level; flush overrides any concurrent push/pop.
  always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      if (push && !pop) level <= level + ONE;
      else if (pop && !push) level <= level - ONE;
    end
  end

  // Sticky overflow flag; a new overflow beats a clear.
  always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      o_ovf_err <= 1'b0;
    end else if (ovf) begin
      o_ovf_err <= 1'b1;
    end else if (i_ovf_clr) begin
      o_ovf_err <= 1'b0;
    end
  end

`ifdef UART_TX_FIFO_IRQ_EN
  logic [ADDR_W:0] level_dn;
  logic            cross;

  // Pop-only step that moves the level from above to at/below threshold.
  always_comb begin
    level_dn = level - ONE;
    cross    = pop && !push &&
               (level > i_thresh) && (level_dn <= i_thresh);
  end

  // One-cycle interrupt pulse; flush suppresses it.
  always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= ~i_flush & (cross | ovf);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table, directed corners and randomized traffic
// against a queue-based model of the transmit FIFO.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       req = 1'b0;
  logic       flush = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] thr = 5'd4;
  logic       full;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [4:0] level;
  logic       empty;
  logic       low;
  logic       ovf_err;
`ifdef UART_TX_FIFO_IRQ_EN
  logic       irq;
`endif

  uart_tx_fifo dut (
    .i_sys_clk  (clk),
    .i_sys_rstn (rst_n),
    .i_wr_en    (wr),
    .i_wr_data  (wdata),
    .o_wr_full  (full),
    .i_flush    (flush),
    .i_ovf_clr  (clr),
    .i_thresh   (thr),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_req   (req),
    .o_level    (level),
    .o_empty    (empty),
    .o_low      (low),
    .o_ovf_err  (ovf_err)
`ifdef UART_TX_FIFO_IRQ_EN
    ,
    .o_irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  bit ovf_m = 1'b0;
  bit irq_m = 1'b0;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    int         lvl;
    logic       vld;
    logic [7:0] dat;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("level", int'(level), n);
    chk("valid", int'(tx_valid), int'(n != 0));
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == 16));
    chk("low", int'(low), int'(n <= int'(thr)));
    chk("ovf_err", int'(ovf_err), int'(ovf_m));
    if (n != 0) chk("head", int'(tx_data), int'(q[0]));
`ifdef UART_TX_FIFO_IRQ_EN
    chk("irq", int'(irq), int'(irq_m));
`endif
  endtask

  task automatic apply(input logic w, input logic [7:0] d,
                       input logic r, input logic f, input logic c);
    int n;
    bit pop_e, push_e, ovf_e;
    wr = w; wdata = d; req = r; flush = f; clr = c;
    n = q.size();
    pop_e  = r && (n != 0);
    push_e = w && ((n != 16) || pop_e);
    ovf_e  = w && (n == 16) && !pop_e;
    irq_m  = !f && (ovf_e ||
             (pop_e && !push_e && n > int'(thr) && (n - 1) <= int'(thr)));
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
    end else begin
      if (pop_e) void'(q.pop_front());
      if (push_e) q.push_back(d);
    end
    if (ovf_e) ovf_m = 1'b1;
    else if (c) ovf_m = 1'b0;
    wr = 1'b0; req = 1'b0; flush = 1'b0; clr = 1'b0;
    check_model();
  endtask

  initial begin
    vt[0] = '{1'b1, 8'hA5, 1'b0, 1, 1'b1, 8'hA5};
    vt[1] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    vt[2] = '{1'b1, 8'h3C, 1'b0, 1, 1'b1, 8'h3C};
    vt[3] = '{1'b1, 8'hC3, 1'b0, 2, 1'b1, 8'h3C};
    vt[4] = '{1'b1, 8'h7E, 1'b1, 2, 1'b1, 8'hC3};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h7E};
    vt[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    vt[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

    #7;
    chk("rst_valid", int'(tx_valid), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(ovf_err), 0);
`ifdef UART_TX_FIFO_IRQ_EN
    chk("rst_irq", int'(irq), 0);
`endif
    #5 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply(vt[i].w, vt[i].d, vt[i].r, 1'b0, 1'b0);
      chk("vec_level", int'(level), vt[i].lvl);
      chk("vec_valid", int'(tx_valid), int'(vt[i].vld));
      if (vt[i].vld) chk("vec_data", int'(tx_data), int'(vt[i].dat));
    end

    for (int i = 0; i < 16; i++) apply(1'b1, 8'(32'h11 + i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 16);
    apply(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", int'(ovf_err), 1);
    chk("ovf_level", int'(level), 16);
    apply(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    chk("ovf_pop_level", int'(level), 16);
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", int'(ovf_err), 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", int'(tx_data), (i < 15) ? (32'h12 + i) : 32'h5A);
      apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", int'(empty), 1);

    for (int i = 0; i < 300; i++) begin
      int n;
      logic w, r, f, c;
      n = q.size();
      w = (n < 3) ? 1'b1 : 1'($urandom_range(0, 1));
      r = (n > 14) ? 1'b1 : ((n < 3) ? 1'b0 : 1'($urandom_range(0, 1)));
      f = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 15) == 0);
      thr = 5'($urandom_range(0, 16));
      apply(w, 8'($urandom), r, f, c);
    end

    thr = 5'd4;
    apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) apply(1'b1, 8'(32'h40 + i), 1'b0, 1'b0, 1'b0);
    apply(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    chk("flush_level", int'(level), 0);
    chk("flush_valid", int'(tx_valid), 0);
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("flush_stays_empty", int'(empty), 1);

    for (int i = 0; i < 17; i++) apply(1'b1, 8'(32'h80 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_ovf", int'(ovf_err), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(tx_valid), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_ovf", int'(ovf_err), 0);
    q.delete();
    ovf_m = 1'b0;
    irq_m = 1'b0;
    #2 rst_n = 1'b1;
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef UART_TX_FIFO_IRQ_EN
    thr = 5'd4;
    for (int i = 0; i < 6; i++) apply(1'b1, 8'(32'h60 + i), 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wm_irq_5", int'(irq), 0);
    apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wm_irq_4", int'(irq), 1);
    chk("wm_low_4", int'(low), 1);
    apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wm_irq_3", int'(irq), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
